// File: rtl/conv_window_gen_if.sv
// ----------------------------------------------------------------------------
// conv_window_gen_if
// Handshake bundle around conv_window_gen: a raster pixel stream in, and
// nine parallel 3x3 window pixels out.
//   master : the window generator (consumes pixels, produces windows)
//   slave  : the environment (pixel source plus window consumer)
// ----------------------------------------------------------------------------
interface conv_window_gen_if #(
  parameter int DATA_W = 8
);

  // Pixel stream, raster order
  logic [DATA_W-1:0] pix_in;
  logic              pix_valid;
  logic              pix_ready;

  // 3x3 window, row-major: win0 = (r-2,c-2), win4 = (r-1,c-1), win8 = (r,c)
  logic [DATA_W-1:0] win0;
  logic [DATA_W-1:0] win1;
  logic [DATA_W-1:0] win2;
  logic [DATA_W-1:0] win3;
  logic [DATA_W-1:0] win4;
  logic [DATA_W-1:0] win5;
  logic [DATA_W-1:0] win6;
  logic [DATA_W-1:0] win7;
  logic [DATA_W-1:0] win8;
  logic              win_valid;
  logic              win_ready;
  logic              row_end;
  logic              frame_end;

  modport master (
    input  pix_in, pix_valid, win_ready,
    output pix_ready,
    output win0, win1, win2, win3, win4, win5, win6, win7, win8,
    output win_valid, row_end, frame_end
  );

  modport slave (
    output pix_in, pix_valid, win_ready,
    input  pix_ready,
    input  win0, win1, win2, win3, win4, win5, win6, win7, win8,
    input  win_valid, row_end, frame_end
  );

endinterface

// File: rtl/conv_window_gen.sv
// ----------------------------------------------------------------------------
// conv_window_gen
// Turns a raster-order pixel stream into every fully populated 3x3 window of
// the frame. Two line buffers hold the previous two rows; a 3x3 register
// array shifts left by one column per accepted pixel, its new right column
// being {lb2[c], lb1[c], pix_in}. A window is presented once its bottom-right
// pixel (r >= 2, c >= 2) has been accepted, and is held while the consumer
// stalls. New pixels are accepted only when the presented window is empty or
// being taken in the same cycle, so a stalled window never gets overwritten.
//
// Optional build macro CONV_WINDOW_STATS_EN adds:
//   win_count[15:0] : wrapping count of window handshakes since reset
//   frame_done      : one-cycle pulse after the last window of a frame is taken
// ----------------------------------------------------------------------------
module conv_window_gen #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  conv_window_gen_if.master  bus
`ifdef CONV_WINDOW_STATS_EN
  ,
  output logic [15:0]        win_count,
  output logic               frame_done
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef logic [DATA_W-1:0] pix_t;

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2, indexed by column.
  pix_t lb1_q [IMG_W];
  pix_t lb2_q [IMG_W];

  // Window registers, row-major (index 0 = top-left, 8 = bottom-right)
  pix_t win_q [9];
  pix_t win_d [9];

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic          row_end_q,   row_end_d;
  logic          frame_end_q, frame_end_d;

  logic pix_ready;
  logic accept;
  logic col_last;
  logic row_last;
  logic completing;
  pix_t lb1_rd;
  pix_t lb2_rd;

  // A pixel may enter only when no window is pending or the pending one leaves now.
  assign pix_ready  = !win_valid_q || bus.win_ready;
  assign accept     = bus.pix_valid && pix_ready;

  assign col_last   = (col_q == COL_LAST);
  assign row_last   = (row_q == ROW_LAST);
  assign completing = (row_q >= RW'(2)) && (col_q >= CW'(2));

  assign lb1_rd = lb1_q[col_q];
  assign lb2_rd = lb2_q[col_q];

  // Next-state for the window array, raster counters and output qualifiers.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    win_d       = win_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    row_end_d   = row_end_q;
    frame_end_d = frame_end_q;

    if (accept) begin
      // Shift left; right column comes from the two line buffers and the new pixel.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = bus.pix_in;

      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) begin
        row_d = row_last ? '0 : row_q + RW'(1);
      end

      // Any accept also retires a window being taken this cycle; it is
      // replaced only if this pixel completes a new one.
      win_valid_d = completing;
      row_end_d   = completing && col_last;
      frame_end_d = completing && col_last && row_last;
    end else if (win_valid_q && bus.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  // Window registers, counters and qualifiers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      row_end_q   <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      row_end_q   <= row_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  // Line buffer update: the old row r-1 value moves down to r-2, pixel goes to r-1.
  always_ff @(posedge clk) begin
    // NOTE: line buffers carry no reset; rows 0 and 1 of every frame overwrite
    // them before any completed window reads them, so stale content is harmless.
    if (accept) begin
      lb2_q[col_q] <= lb1_rd;
      lb1_q[col_q] <= bus.pix_in;
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.win0      = win_q[0];
  assign bus.win1      = win_q[1];
  assign bus.win2      = win_q[2];
  assign bus.win3      = win_q[3];
  assign bus.win4      = win_q[4];
  assign bus.win5      = win_q[5];
  assign bus.win6      = win_q[6];
  assign bus.win7      = win_q[7];
  assign bus.win8      = win_q[8];
  assign bus.win_valid = win_valid_q;
  assign bus.row_end   = row_end_q;
  assign bus.frame_end = frame_end_q;

`ifdef CONV_WINDOW_STATS_EN
  logic [15:0] win_count_q, win_count_d;
  logic        frame_done_q, frame_done_d;
  logic        win_hs;

  assign win_hs = win_valid_q && bus.win_ready;

  // Handshake counter (free-wrapping) and end-of-frame pulse.
  always_comb begin
    win_count_d  = win_hs ? win_count_q + 16'd1 : win_count_q;
    frame_done_d = win_hs && frame_end_q;
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      win_count_q  <= win_count_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_count  = win_count_q;
  assign frame_done = frame_done_q;
`endif

  // A stalled window stays presented until it is taken.
  a_stall_hold : assert property (@(posedge clk)
    !reset && win_valid_q && !bus.win_ready |=> win_valid_q);

  // The last window of a frame is always the last of its row.
  a_frame_row : assert property (@(posedge clk) frame_end_q |-> row_end_q);

endmodule
